// File: rtl/lsu_mem_ctrl.sv
// Memory-stage controller: takes one load/store/pass-through op from EX/MEM,
// issues a single lane-aligned request on the 64-bit data bus, waits for the
// response (with a bounded wait), extends load data and hands the result to WB.
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1; a valid source holds its payload stable until that edge.
module lsu_mem_ctrl #(
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 255
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_addr,
   input  logic [1:0]      in_size,
   input  logic            in_unsigned,
   input  logic            in_wen,
   input  logic            in_ren,
   input  logic [XLEN-1:0] in_wdata,
   input  logic [XLEN-1:0] in_alu,
   input  logic [4:0]      in_rd,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   output logic            req_wen,
   output logic [XLEN-1:0] req_wdata,
   output logic [7:0]      req_mask,
   input  logic            resp_valid,
   input  logic [XLEN-1:0] resp_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [4:0]      out_rd,
   output logic [1:0]      out_err,
   output logic [1:0]      dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   wait_cnt;
   logic [2:0]      lat_off;
   logic [1:0]      lat_size;
   logic            lat_unsigned;
   logic            lat_wen;

   logic            is_mem;
   logic            misaligned;
   logic [7:0]      size_mask;
   logic [7:0]      lane_mask;
   logic [XLEN-1:0] rd_shift;
   logic            sign_en;
   logic [XLEN-1:0] load_ext;

   assign dbg_state = state;
   assign is_mem    = in_wen | in_ren;

   // Alignment check and byte-lane mask for the op being offered.
   always_comb begin
      misaligned = 1'b0;
      size_mask  = 8'h01;
      case (in_size)
         2'd0: begin misaligned = 1'b0;            size_mask = 8'h01; end
         2'd1: begin misaligned = in_addr[0];      size_mask = 8'h03; end
         2'd2: begin misaligned = |in_addr[1:0];   size_mask = 8'h0F; end
         default: begin misaligned = |in_addr[2:0]; size_mask = 8'hFF; end
      endcase
      lane_mask = size_mask << in_addr[2:0];
   end

   // Pick the addressed bytes out of the response and extend to XLEN.
   always_comb begin
      rd_shift = resp_rdata >> {lat_off, 3'b000};
      sign_en  = ~lat_unsigned;
      case (lat_size)
         2'd0:    load_ext = {{(XLEN-8){sign_en & rd_shift[7]}},   rd_shift[7:0]};
         2'd1:    load_ext = {{(XLEN-16){sign_en & rd_shift[15]}}, rd_shift[15:0]};
         2'd2:    load_ext = {{(XLEN-32){sign_en & rd_shift[31]}}, rd_shift[31:0]};
         default: load_ext = rd_shift;
      endcase
   end

   // Transaction FSM; every output is a register updated here.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         lat_off      <= '0;
         lat_size     <= '0;
         lat_unsigned <= 1'b0;
         lat_wen      <= 1'b0;
         in_ready     <= 1'b1;
         req_valid    <= 1'b0;
         req_addr     <= '0;
         req_wen      <= 1'b0;
         req_wdata    <= '0;
         req_mask     <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_rd       <= '0;
         out_err      <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  lat_off      <= in_addr[2:0];
                  lat_size     <= in_size;
                  lat_unsigned <= in_unsigned;
                  lat_wen      <= in_wen;
                  out_rd       <= in_rd;
                  in_ready     <= 1'b0;
                  if (!is_mem) begin
                     out_data  <= in_alu;
                     out_err   <= 2'd0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else if (misaligned) begin
                     out_data  <= '0;
                     out_err   <= 2'd1;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     req_valid <= 1'b1;
                     req_addr  <= {in_addr[XLEN-1:3], 3'b000};
                     req_wen   <= in_wen;
                     req_wdata <= in_wdata << {in_addr[2:0], 3'b000};
                     req_mask  <= lane_mask;
                     state     <= REQ;
                  end
               end
            end
            REQ: begin
               if (req_ready) begin
                  req_valid <= 1'b0;
                  req_addr  <= '0;
                  req_wen   <= 1'b0;
                  req_wdata <= '0;
                  req_mask  <= '0;
                  wait_cnt  <= '0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (resp_valid) begin
                  out_data  <= lat_wen ? '0 : load_ext;
                  out_err   <= 2'd0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (wait_cnt == CW'(TIMEOUT)) begin
                  out_data  <= '0;
                  out_err   <= 2'd2;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_err   <= 2'd0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized ops
// checked against a byte-level reference model and an expected-result queue.
module tb_lsu_mem_ctrl;

   localparam int TIMEOUT = 255;

   // clock / reset
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   logic        in_valid, in_ready, in_unsigned, in_wen, in_ren;
   logic [63:0] in_addr, in_wdata, in_alu;
   logic [1:0]  in_size;
   logic [4:0]  in_rd;
   logic        req_valid, req_ready, req_wen;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_mask;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        out_valid, out_ready;
   logic [63:0] out_data;
   logic [4:0]  out_rd;
   logic [1:0]  out_err;
   logic [1:0]  dbg_state;

   lsu_mem_ctrl #(.XLEN(64), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_size(in_size),
      .in_unsigned(in_unsigned), .in_wen(in_wen), .in_ren(in_ren), .in_wdata(in_wdata),
      .in_alu(in_alu), .in_rd(in_rd),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
      .req_wdata(req_wdata), .req_mask(req_mask),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
      .out_err(out_err), .dbg_state(dbg_state)
   );

   // scoreboard
   logic [63:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [63:0] obs_req_wdata, obs_req_addr, obs_out_data;
   logic [7:0]  obs_req_mask;
   logic        obs_req_wen;
   logic [1:0]  obs_out_err;

   // reference: take 1<<size bytes starting at byte off, then extend
   function automatic logic [63:0] load_model(input logic [63:0] rdata, input logic [2:0] off,
                                              input logic [1:0] size, input logic uns);
      int          nbytes;
      logic [63:0] v, keep;
      nbytes = 1 << size;
      v = rdata >> (8 * off);
      if (nbytes < 8) begin
         keep = (64'd1 << (8 * nbytes)) - 64'd1;
         v = v & keep;
         if (!uns && v[8*nbytes-1]) v = v | ~keep;
      end
      return v;
   endfunction

   // driver: offer one op and let it be accepted
   task automatic drive_op(input logic [63:0] addr, input logic [1:0] size, input logic uns,
                           input logic wen, input logic ren, input logic [63:0] wdata,
                           input logic [63:0] alu, input logic [4:0] rd);
      @(negedge clock);
      in_valid = 1'b1; in_addr = addr; in_size = size; in_unsigned = uns;
      in_wen = wen; in_ren = ren; in_wdata = wdata; in_alu = alu; in_rd = rd;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: in_ready=%b want 1", in_ready); end
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   // driver: issue a load and complete the bus request handshake (ends in first WAIT cycle)
   task automatic issue_load(input logic [63:0] addr, input logic [1:0] size, input logic uns);
      drive_op(addr, size, uns, 1'b0, 1'b1, 64'd0, 64'd0, 5'd7);
      req_ready = 1'b1;
      @(negedge clock);
      req_ready = 1'b0;
   endtask

   // one full transaction with model-derived expectations and optional backpressure
   task automatic run_op(input logic [63:0] addr, input logic [1:0] size, input logic uns,
                         input logic wen, input logic ren, input logic [63:0] wdata,
                         input logic [63:0] alu, input logic [4:0] rd, input logic [63:0] rdata,
                         input int req_hold, input int resp_dly, input int out_hold);
      logic        mem, mis;
      logic [2:0]  off;
      logic [63:0] exp_data, exp_wdata, exp_addr, hold_data;
      logic [7:0]  exp_mask;
      logic [1:0]  exp_err;
      int          nbytes;
      nbytes    = 1 << size;
      off       = addr[2:0];
      mem       = wen | ren;
      mis       = mem && ((addr % 64'(nbytes)) != 64'd0);
      exp_mask  = 8'(((1 << nbytes) - 1) << off);
      exp_wdata = wdata << (8 * off);
      exp_addr  = addr - 64'(off);
      exp_err   = mis ? 2'd1 : 2'd0;
      if (!mem)            exp_data = alu;
      else if (mis || wen) exp_data = 64'd0;
      else                 exp_data = load_model(rdata, off, size, uns);
      exp_q.push_back(exp_data);

      drive_op(addr, size, uns, wen, ren, wdata, alu, rd);
      if (mem && !mis) begin
         obs_req_addr = req_addr; obs_req_wdata = req_wdata;
         obs_req_mask = req_mask; obs_req_wen = req_wen;
         checks++;
         if (req_valid !== 1'b1 || req_addr !== exp_addr || req_wen !== wen ||
             req_wdata !== exp_wdata || req_mask !== exp_mask) begin
            errors++;
            $display("FAIL req_fields: v=%b a=%h w=%b d=%h m=%h want v=1 a=%h w=%b d=%h m=%h",
                     req_valid, req_addr, req_wen, req_wdata, req_mask,
                     exp_addr, wen, exp_wdata, exp_mask);
         end
         for (int i = 0; i < req_hold; i++) begin
            @(negedge clock);
            checks++;
            if (req_valid !== 1'b1 || req_addr !== exp_addr || req_wdata !== exp_wdata ||
                req_mask !== exp_mask || in_ready !== 1'b0 || out_valid !== 1'b0) begin
               errors++;
               $display("FAIL req_hold: v=%b a=%h d=%h m=%h in_ready=%b out_valid=%b want held request",
                        req_valid, req_addr, req_wdata, req_mask, in_ready, out_valid);
            end
         end
         req_ready = 1'b1;
         @(negedge clock);
         req_ready = 1'b0;
         checks++;
         if (req_valid !== 1'b0 || req_mask !== 8'd0 || req_wdata !== 64'd0 || req_addr !== 64'd0) begin
            errors++;
            $display("FAIL req_drop: v=%b a=%h d=%h m=%h want all 0", req_valid, req_addr, req_wdata, req_mask);
         end
         repeat (resp_dly) @(negedge clock);
         resp_valid = 1'b1; resp_rdata = rdata;
         @(negedge clock);
         resp_valid = 1'b0; resp_rdata = {$urandom, $urandom};
      end else begin
         checks++;
         if (req_valid !== 1'b0) begin errors++; $display("FAIL no_req: req_valid=%b want 0", req_valid); end
      end

      hold_data = exp_q.pop_front();
      obs_out_data = out_data; obs_out_err = out_err;
      checks++;
      if (out_valid !== 1'b1 || out_data !== hold_data || out_rd !== rd || out_err !== exp_err) begin
         errors++;
         $display("FAIL out_result: v=%b d=%h rd=%0d err=%0d want v=1 d=%h rd=%0d err=%0d",
                  out_valid, out_data, out_rd, out_err, hold_data, rd, exp_err);
      end
      for (int i = 0; i < out_hold; i++) begin
         @(negedge clock);
         checks++;
         if (out_valid !== 1'b1 || out_data !== hold_data || out_err !== exp_err || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL out_hold: v=%b d=%h err=%0d in_ready=%b want v=1 d=%h err=%0d in_ready=0",
                     out_valid, out_data, out_err, in_ready, hold_data, exp_err);
         end
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_err !== 2'd0) begin
         errors++;
         $display("FAIL out_release: v=%b in_ready=%b err=%0d want 0 1 0", out_valid, in_ready, out_err);
      end
   endtask

   task automatic test_reset;
      checks++;
      if (in_ready !== 1'b1 || req_valid !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%b req_valid=%b out_valid=%b want 1 0 0", in_ready, req_valid, out_valid);
      end
      checks++;
      if (req_addr !== 64'd0 || req_wdata !== 64'd0 || req_mask !== 8'd0 || req_wen !== 1'b0) begin
         errors++;
         $display("FAIL reset_req: a=%h d=%h m=%h w=%b want 0", req_addr, req_wdata, req_mask, req_wen);
      end
      checks++;
      if (out_data !== 64'd0 || out_rd !== 5'd0 || out_err !== 2'd0) begin
         errors++;
         $display("FAIL reset_out: d=%h rd=%0d err=%0d want 0", out_data, out_rd, out_err);
      end
   endtask

   task automatic test_store_byte;
      run_op(64'h8000_0003, 2'd0, 1'b0, 1'b1, 1'b0, 64'hAB, 64'd0, 5'd3, 64'd0, 0, 0, 0);
      checks++;
      if (obs_req_addr !== 64'h8000_0000 || obs_req_mask !== 8'h08 ||
          obs_req_wdata !== 64'h0000_0000_AB00_0000 || obs_req_wen !== 1'b1) begin
         errors++;
         $display("FAIL sb_literal: a=%h m=%h d=%h w=%b want 80000000 08 00000000ab000000 1",
                  obs_req_addr, obs_req_mask, obs_req_wdata, obs_req_wen);
      end
   endtask

   task automatic test_load_half;
      run_op(64'h8000_0006, 2'd1, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 5'd9, 64'h8001_0000_0000_0000, 0, 1, 0);
      checks++;
      if (obs_out_data !== 64'hFFFF_FFFF_FFFF_8001) begin
         errors++; $display("FAIL lh_signed: got %h want ffffffffffff8001", obs_out_data);
      end
      run_op(64'h8000_0006, 2'd1, 1'b1, 1'b0, 1'b1, 64'd0, 64'd0, 5'd9, 64'h8001_0000_0000_0000, 0, 0, 0);
      checks++;
      if (obs_out_data !== 64'h0000_0000_0000_8001) begin
         errors++; $display("FAIL lhu: got %h want 0000000000008001", obs_out_data);
      end
   endtask

   task automatic test_misaligned;
      run_op(64'h8000_0002, 2'd2, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 5'd4, 64'd0, 0, 0, 0);
      checks++;
      if (obs_out_err !== 2'd1 || obs_out_data !== 64'd0) begin
         errors++; $display("FAIL lw_misaligned: err=%0d d=%h want 1 0", obs_out_err, obs_out_data);
      end
   endtask

   task automatic test_passthrough;
      run_op(64'h1234, 2'd3, 1'b0, 1'b0, 1'b0, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 5'd31, 64'd0, 0, 0, 2);
   endtask

   task automatic test_backpressure;
      run_op(64'h8000_0010, 2'd2, 1'b0, 1'b1, 1'b0, 64'h1122_3344, 64'd0, 5'd12, 64'd0, 5, 2, 3);
      run_op(64'h8000_0014, 2'd2, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 5'd13, 64'h9ABC_DEF0_1234_5678, 5, 0, 3);
   endtask

   task automatic test_timeout;
      logic [63:0] r;
      issue_load(64'h8000_0020, 2'd3, 1'b0);
      repeat (TIMEOUT) @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL timeout_early: out_valid=%b want 0", out_valid); end
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || out_err !== 2'd2 || out_data !== 64'd0) begin
         errors++; $display("FAIL timeout_err: v=%b err=%0d d=%h want 1 2 0", out_valid, out_err, out_data);
      end
      out_ready = 1'b1; @(negedge clock); out_ready = 1'b0;

      r = {$urandom, $urandom};
      issue_load(64'h8000_0024, 2'd2, 1'b0);
      repeat (TIMEOUT) @(negedge clock);
      resp_valid = 1'b1; resp_rdata = r;
      @(negedge clock);
      resp_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_err !== 2'd0 || out_data !== load_model(r, 3'd4, 2'd2, 1'b0)) begin
         errors++;
         $display("FAIL timeout_race: v=%b err=%0d d=%h want 1 0 %h", out_valid, out_err, out_data,
                  load_model(r, 3'd4, 2'd2, 1'b0));
      end
      out_ready = 1'b1; @(negedge clock); out_ready = 1'b0;
   endtask

   task automatic test_reset_in_wait;
      issue_load(64'h8000_0010, 2'd3, 1'b0);
      repeat (3) @(negedge clock);
      reset_n = 1'b0;
      #1;
      test_reset();
      @(negedge clock);
      reset_n = 1'b1;
      resp_valid = 1'b1; resp_rdata = 64'hFFFF_0000_FFFF_0000;
      @(negedge clock);
      resp_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || req_valid !== 1'b0) begin
         errors++;
         $display("FAIL late_resp: out_valid=%b in_ready=%b req_valid=%b want 0 1 0", out_valid, in_ready, req_valid);
      end
      run_op(64'h8000_0008, 2'd3, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 5'd21, {$urandom, $urandom}, 0, 0, 0);
   endtask

   task automatic test_random;
      logic [63:0] addr;
      logic [1:0]  size;
      logic [2:0]  off;
      int          kind;
      for (int n = 0; n < 40; n++) begin
         size = 2'($urandom_range(0, 3));
         off  = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) off = off & ~3'((1 << size) - 1);
         addr = 64'h8000_0000 + 64'({$urandom_range(0, 255), 3'b000}) + 64'(off);
         kind = $urandom_range(0, 3);
         run_op(addr, size, 1'($urandom_range(0, 1)), kind[1], kind[0], {$urandom, $urandom},
                {$urandom, $urandom}, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      in_valid = 1'b0; in_addr = '0; in_size = '0; in_unsigned = 1'b0; in_wen = 1'b0;
      in_ren = 1'b0; in_wdata = '0; in_alu = '0; in_rd = '0;
      req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0; out_ready = 1'b0;
      repeat (3) @(negedge clock);
      test_reset();
      reset_n = 1'b1;
      @(negedge clock);
      test_store_byte();
      test_load_half();
      test_misaligned();
      test_passthrough();
      test_backpressure();
      test_timeout();
      test_reset_in_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Multi-cycle memory-stage controller between the EX/MEM pipeline register (upstream) and the 64-bit data-memory bus (downstream).
- Accepts one load, store or pass-through op per transaction. Aligns store data and byte mask to the 8-byte lane and issues one bus request.
- Waits for the bus response, then sign/zero-extends load data. Hands the result to the WB stage through a valid/ready handshake.
- Replaces the single-cycle combinational access, so memory latency can vary.

Parameters:
XLEN, 64, data/address width; only 64 is supported.
TIMEOUT, 255, maximum WAIT cycles before the op is aborted with an error.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
in_valid  in  1  EX/MEM holds a valid op.
in_ready  out  1  controller can accept an op.
in_addr  in  64  effective byte address.
in_size  in  2  0=byte, 1=half, 2=word, 3=dword.
in_unsigned  in  1  zero-extend load result when 1.
in_wen  in  1  store.
in_ren  in  1  load (in_wen has priority if both are 1).
in_wdata  in  64  store data, right-justified.
in_alu  in  64  pass-through result for non-memory ops.
in_rd  in  5  destination register tag.
req_valid  out  1  bus request valid.
req_ready  in  1  bus accepts the request.
req_addr  out  64  in_addr with bits [2:0] cleared.
req_wen  out  1  request is a write.
req_wdata  out  64  in_wdata << (8*addr[2:0]).
req_mask  out  8  ((1<<(1<<size))-1) << addr[2:0].
resp_valid  in  1  bus response or write acknowledge, one-cycle pulse.
resp_rdata  in  64  raw 8-byte-aligned read data.
out_valid  out  1  result valid to WB.
out_ready  in  1  WB accepts the result.
out_data  out  64  extended load data, in_alu, or 0 for stores and errors.
out_rd  out  5  latched in_rd.
out_err  out  2  0=ok, 1=misaligned, 2=bus timeout.

Behaviour:

Reset:
- reset_n low forces state IDLE and clears all registers. This aborts any transaction in progress.
- Output values during reset: in_ready=1; req_valid=0; out_valid=0; out_data=0; out_rd=0; out_err=0; req_addr/wdata/mask=0; req_wen=0; timeout counter=0.
- An in-flight bus response arriving after reset is ignored.

States:
- IDLE, REQ, WAIT, DONE.
- in_ready=1 only in IDLE.

IDLE:
- On in_valid & in_ready, latch every input field.
- Misaligned means addr[size-1:0] != 0 (size 0 is never misaligned).
- No memory op: go to DONE with out_data=in_alu.
- Memory op and misaligned: go to DONE with out_err=1, out_data=0, and no bus request issued.
- Memory op otherwise: go to REQ.

REQ:
- req_valid=1. req_addr, req_wen, req_wdata and req_mask stay stable until req_ready.
- On req_valid & req_ready, go to WAIT and clear the counter.
- Request fields drop to 0 when req_valid=0.

WAIT:
- On resp_valid:
  - Load: out_data = extend((resp_rdata >> 8*addr[2:0]) truncated to 8<<size bits), sign-extended unless in_unsigned or size=3.
  - Store: out_data=0.
  - Go to DONE.
- Otherwise the counter increments. When the counter equals TIMEOUT, go to DONE with out_err=2, out_data=0.
- resp_valid in the same cycle as the timeout wins, and the op completes normally.
- resp_valid in any state other than WAIT is ignored.

DONE:
- out_valid=1. out_data, out_rd and out_err stay stable until out_ready.
- On out_ready, go to IDLE. out_valid falls, in_ready rises the next cycle, and out_err clears.
- No bypass: the next op is accepted no earlier than the cycle after the out handshake.

Latency (zero-wait bus, out_ready=1):
- Memory op, out_valid first asserted:
  - accept at cycle 0
  - REQ at cycle 1
  - WAIT at cycle 2
  - resp at cycle 2 (DONE/out_valid at cycle 3)
  - resp at cycle N: out_valid at cycle N+1
- Pass-through or misaligned op: out_valid at cycle 1.

Test Plan:
- Aligned sb: addr=0x80000003, size=0, wdata=0xAB -> req_addr=0x80000000, req_mask=0x08, req_wdata=0x00000000AB000000, req_wen=1; ack resp -> out_valid with out_data=0, out_err=0.
- lh signed: addr=0x80000006, resp_rdata=0x8001_0000_0000_0000 -> out_data=0xFFFFFFFFFFFF8001. Same with in_unsigned=1 -> 0x0000000000008001.
- lw at addr=0x80000002 (misaligned) -> no req_valid ever; out_valid one cycle after accept with out_err=1, out_data=0.
- Backpressure:
  - req_ready low 5 cycles -> req_* held stable, no state change.
  - out_ready low 3 cycles -> out_valid and out_data held.
  - in_ready stays 0 throughout.
- Timeout: req accepted, resp_valid never asserted -> out_err=2 exactly TIMEOUT+1 cycles after entering WAIT. Also: resp_valid on the timeout cycle -> out_err=0 with load data.
- reset_n pulsed low while in WAIT -> outputs immediately at reset values. A late resp_valid is ignored. The next ld at addr=0x80000008 completes with the correct dword.
